// File: rtl/tdc_stamp_fifo_if.sv
// Hit input, FWFT readout handshake and status signals of the timestamp FIFO.
interface tdc_stamp_fifo_if #(
    parameter int FINE_WIDTH   = 16,
    parameter int COARSE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int DROP_WIDTH   = 16
);
    localparam int WORD_W = 1 + COARSE_WIDTH + FINE_WIDTH;
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    logic                  i_enable;
    logic                  i_fine_valid;
    logic [FINE_WIDTH-1:0] i_fine_code;
    logic [WORD_W-1:0]     o_tdata;
    logic                  o_tvalid;
    logic                  i_tready;
    logic [LVL_W-1:0]      o_fifo_level;
    logic [DROP_WIDTH-1:0] o_drop_cnt;
    logic                  o_marker_lost;

    modport master (
        input  i_enable, i_fine_valid, i_fine_code, i_tready,
        output o_tdata, o_tvalid, o_fifo_level, o_drop_cnt, o_marker_lost
    );

    modport slave (
        output i_enable, i_fine_valid, i_fine_code, i_tready,
        input  o_tdata, o_tvalid, o_fifo_level, o_drop_cnt, o_marker_lost
    );
endinterface

// File: rtl/tdc_stamp_fifo.sv
// Extends fine codes with a coarse cycle count, inserts rollover markers and
// buffers the resulting timestamps in a first-word-fall-through FIFO.
module tdc_stamp_fifo #(
    parameter int FINE_WIDTH   = 16,
    parameter int COARSE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int DROP_WIDTH   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    tdc_stamp_fifo_if.master  bus
);
    localparam int          WORD_W   = 1 + COARSE_WIDTH + FINE_WIDTH;
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [COARSE_WIDTH-1:0] coarse_p0;
    logic [FINE_WIDTH-1:0]   seq_p0;
    logic                    pending_p0;
    logic                    lost;
    logic                    wrap;

    logic                    vld_p1;
    logic [WORD_W-1:0]       hit_word_p1;

    logic [WORD_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             level;
    logic [DROP_WIDTH-1:0]   drop_cnt;

    logic                    full;
    logic                    pop;
    logic                    wr_marker;
    logic                    wr_en;
    logic [WORD_W-1:0]       wr_word;

    // Stage p0: coarse time base and rollover marker bookkeeping
    assign wrap = bus.i_enable & (&coarse_p0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            coarse_p0  <= '0;
            seq_p0     <= '0;
            pending_p0 <= 1'b0;
            lost       <= 1'b0;
        end else if (!bus.i_enable) begin
            coarse_p0  <= '0;
            seq_p0     <= '0;
            pending_p0 <= 1'b0;
        end else begin
            coarse_p0 <= coarse_p0 + 1'b1;
            if (wrap) begin
                // An unwritten marker is overtaken; the pending one takes the new sequence number.
                seq_p0     <= seq_p0 + 1'b1;
                pending_p0 <= 1'b1;
                if (pending_p0 && !wr_marker)
                    lost <= 1'b1;
            end else if (wr_marker) begin
                pending_p0 <= 1'b0;
            end
        end
    end

    // Stage p1: registered hit word awaiting its FIFO write
    always_ff @(posedge i_clk) begin
        if (i_reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= bus.i_enable & bus.i_fine_valid;
    end

    always_ff @(posedge i_clk) begin
        if (bus.i_enable && bus.i_fine_valid)
            hit_word_p1 <= {1'b0, coarse_p0, bus.i_fine_code};
    end

    // Stage p2: write arbitration and FIFO storage; fullness ignores a same-cycle pop
    assign full      = (level == FULL_LVL);
    assign pop       = (level != '0) & bus.i_tready;
    assign wr_marker = ~vld_p1 & pending_p0 & ~full;
    assign wr_en     = (vld_p1 & ~full) | wr_marker;
    assign wr_word   = vld_p1 ? hit_word_p1 : {1'b1, {COARSE_WIDTH{1'b0}}, seq_p0};

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            drop_cnt <= '0;
        else if (vld_p1 && full)
            drop_cnt <= sat_inc(drop_cnt);
    end

    assign bus.o_tvalid      = (level != '0);
    assign bus.o_tdata       = bus.o_tvalid ? mem[rd_ptr] : '0;
    assign bus.o_fifo_level  = level;
    assign bus.o_drop_cnt    = drop_cnt;
    assign bus.o_marker_lost = lost;
endmodule

// File: tb/tb_tdc_stamp_fifo.sv
// Randomised and directed checks of tdc_stamp_fifo against a queue-based timestamp model.
module tb_tdc_stamp_fifo;
    localparam int FW    = 16;
    localparam int CW    = 8;
    localparam int DEPTH = 16;
    localparam int DW    = 4;
    localparam int WW    = 1 + CW + FW;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int VW    = WW + 1 + LW + DW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdc_stamp_fifo_if #(.FINE_WIDTH(FW), .COARSE_WIDTH(CW), .FIFO_DEPTH(DEPTH), .DROP_WIDTH(DW)) bus ();

    tdc_stamp_fifo #(.FINE_WIDTH(FW), .COARSE_WIDTH(CW), .FIFO_DEPTH(DEPTH), .DROP_WIDTH(DW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_coarse, m_seq, m_drops;
    bit            m_pending, m_lost, m_stg;
    logic [WW-1:0] m_stg_word;
    logic [WW-1:0] m_q[$];
    logic [WW-1:0] seen[$];

    function automatic logic [WW-1:0] hit_word(int c, logic [FW-1:0] f);
        return {1'b0, CW'(c), f};
    endfunction

    function automatic logic [WW-1:0] marker_word(int s);
        return {1'b1, CW'(0), FW'(s)};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [WW-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        return {head, m_q.size() != 0, LW'(m_q.size()), DW'(m_drops), m_lost};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {bus.o_tdata, bus.o_tvalid, bus.o_fifo_level, bus.o_drop_cnt, bus.o_marker_lost};
    endfunction

    task automatic model_step(bit r, bit en, bit fv, logic [FW-1:0] code, bit rdy);
        bit was_full, do_pop;
        if (r) begin
            m_q.delete();
            m_coarse = 0; m_seq = 0; m_drops = 0;
            m_pending = 0; m_lost = 0; m_stg = 0;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        do_pop   = (m_q.size() != 0) && rdy;
        if (m_stg) begin
            if (was_full) m_drops = (m_drops == (1 << DW) - 1) ? m_drops : m_drops + 1;
            else          m_q.push_back(m_stg_word);
        end else if (m_pending && !was_full) begin
            m_q.push_back(marker_word(m_seq));
            m_pending = 0;
        end
        if (do_pop) void'(m_q.pop_front());
        m_stg      = en && fv;
        m_stg_word = hit_word(m_coarse, code);
        if (!en) begin
            m_coarse = 0; m_seq = 0; m_pending = 0;
        end else if (m_coarse == (1 << CW) - 1) begin
            m_coarse = 0;
            m_seq    = (m_seq + 1) % (1 << FW);
            if (m_pending) m_lost = 1;
            m_pending = 1;
        end else begin
            m_coarse++;
        end
    endtask

    task automatic tick(bit r, bit en, bit fv, logic [FW-1:0] code, bit rdy);
        rst              = r;
        bus.i_enable     = en;
        bus.i_fine_valid = fv;
        bus.i_fine_code  = code;
        bus.i_tready     = rdy;
        @(posedge clk);
        model_step(r, en, fv, code, rdy);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, '0, 0);
        tick(1, 0, 0, '0, 0);
        n_tests++;
        if (act_vec() !== '0) begin
            n_fail++; $display("FAIL reset_state got=%h want=0", act_vec());
        end
        tick(0, 0, 0, '0, 1);
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_release got=%h want=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_single_hit();
        logic [WW-1:0] want;
        want = {1'b0, 8'h10, 16'h00A5};
        tick(1, 0, 0, '0, 1);
        for (int i = 0; i < 16; i++) tick(0, 1, 0, '0, 1);
        tick(0, 1, 1, 16'h00A5, 1);
        n_tests++;
        if (bus.o_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL hit_latency_n1 tvalid=%b want=0", bus.o_tvalid);
        end
        tick(0, 1, 0, '0, 1);
        n_tests++;
        if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== want) begin
            n_fail++; $display("FAIL hit_word tvalid=%b tdata=%h want=%h", bus.o_tvalid, bus.o_tdata, want);
        end
        tick(0, 1, 0, '0, 1);
        n_tests++;
        if (bus.o_fifo_level !== '0 || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL hit_pop level=%0d want=0", bus.o_fifo_level);
        end
    endtask

    task automatic test_rollover();
        seen.delete();
        tick(1, 0, 0, '0, 1);
        for (int i = 0; i < 2 * (1 << CW) + 8; i++) begin
            tick(0, 1, 0, '0, 1);
            if (bus.o_tvalid) seen.push_back(bus.o_tdata);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rollover cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
        end
        n_tests++;
        if (seen.size() != 2 || seen[0] !== marker_word(1) || seen[1] !== marker_word(2)) begin
            n_fail++;
            $display("FAIL rollover_markers count=%0d first=%h want=%h", seen.size(),
                     (seen.size() > 0) ? seen[0] : '0, marker_word(1));
        end
    endtask

    task automatic test_wrap_hit();
        logic [FW-1:0] code;
        code = FW'($urandom);
        seen.delete();
        tick(1, 0, 0, '0, 1);
        for (int i = 0; i < (1 << CW) - 1; i++) tick(0, 1, 0, '0, 1);
        tick(0, 1, 1, code, 1);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 0, '0, 1);
            if (bus.o_tvalid) seen.push_back(bus.o_tdata);
        end
        n_tests++;
        if (seen.size() != 2 || seen[0] !== {1'b0, 8'hFF, code} || seen[1] !== marker_word(1)) begin
            n_fail++;
            $display("FAIL wrap_hit_order count=%0d first=%h want=%h", seen.size(),
                     (seen.size() > 0) ? seen[0] : '0, {1'b0, 8'hFF, code});
        end
    endtask

    task automatic test_full_drop();
        logic [FW-1:0] codes[20];
        tick(1, 0, 0, '0, 0);
        for (int i = 0; i < 20; i++) begin
            codes[i] = FW'($urandom);
            tick(0, 1, 1, codes[i], 0);
        end
        tick(0, 1, 0, '0, 0);
        n_tests++;
        if (bus.o_fifo_level !== LW'(16) || bus.o_drop_cnt !== DW'(4) ||
            bus.o_tdata !== {1'b0, 8'h00, codes[0]}) begin
            n_fail++;
            $display("FAIL full_drop level=%0d drops=%0d tdata=%h want 16/4/%h",
                     bus.o_fifo_level, bus.o_drop_cnt, bus.o_tdata, {1'b0, 8'h00, codes[0]});
        end
        for (int i = 0; i < 16; i++) tick(0, 1, 1, FW'($urandom), 0);
        tick(0, 1, 0, '0, 0);
        n_tests++;
        if (bus.o_drop_cnt !== {DW{1'b1}} || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL drop_saturate drops=%0d want=%0d", bus.o_drop_cnt, (1 << DW) - 1);
        end
        seen.delete();
        for (int i = 0; i < 18; i++) begin
            if (bus.o_tvalid) seen.push_back(bus.o_tdata);
            tick(0, 1, 0, '0, 1);
        end
        n_tests++;
        if (seen.size() != 16) begin
            n_fail++; $display("FAIL drain_count got=%0d want=16", seen.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_tests++;
                if (seen[i] !== {1'b0, CW'(i), codes[i]}) begin
                    n_fail++; $display("FAIL drain_order idx=%0d got=%h want=%h", i, seen[i], {1'b0, CW'(i), codes[i]});
                end
            end
        end
    endtask

    task automatic test_full_marker();
        tick(1, 0, 0, '0, 0);
        for (int i = 0; i < 16; i++) tick(0, 1, 1, FW'($urandom), 0);
        for (int i = 16; i < (1 << CW) + 2; i++) tick(0, 1, 0, '0, 0);
        n_tests++;
        if (bus.o_fifo_level !== LW'(16) || bus.o_marker_lost !== 1'b0 || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL marker_pending_full level=%0d lost=%b want 16/0", bus.o_fifo_level, bus.o_marker_lost);
        end
        tick(0, 1, 0, '0, 1);
        tick(0, 1, 0, '0, 0);
        n_tests++;
        if (bus.o_fifo_level !== LW'(16) || bus.o_marker_lost !== 1'b0 || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL marker_after_pop level=%0d lost=%b want 16/0", bus.o_fifo_level, bus.o_marker_lost);
        end
        for (int i = 0; i < 2 * (1 << CW); i++) begin
            tick(0, 1, 0, '0, 0);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL marker_lost_run cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
        end
        n_tests++;
        if (bus.o_marker_lost !== 1'b1) begin
            n_fail++; $display("FAIL marker_lost got=%b want=1", bus.o_marker_lost);
        end
        for (int i = 0; i < 24; i++) begin
            tick(0, 1, 0, '0, 1);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL marker_drain cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, '0, 0);
        for (int i = 0; i < 8; i++) tick(0, 1, 1, FW'($urandom), 0);
        tick(0, 1, 0, '0, 1);
        tick(0, 1, 0, '0, 0);
        tick(1, 1, 1, FW'($urandom), 1);
        n_tests++;
        if (act_vec() !== '0) begin
            n_fail++; $display("FAIL reset_mid got=%h want=0", act_vec());
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, '0, i % 2);
            n_tests++;
            if (bus.o_tvalid !== 1'b0) begin
                n_fail++; $display("FAIL reset_mid_residue cyc=%0d tvalid=%b want=0", i, bus.o_tvalid);
            end
        end
    endtask

    task automatic test_disable();
        tick(1, 0, 0, '0, 0);
        for (int i = 0; i < 18; i++) tick(0, 1, 1, FW'($urandom), 0);
        tick(0, 1, 0, '0, 0);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, FW'($urandom), 0);
        n_tests++;
        if (bus.o_fifo_level !== LW'(16) || bus.o_drop_cnt !== DW'(2) || act_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL disable_full level=%0d drops=%0d want 16/2", bus.o_fifo_level, bus.o_drop_cnt);
        end
        tick(1, 0, 0, '0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, FW'($urandom), 1);
        n_tests++;
        if (bus.o_fifo_level !== '0 || bus.o_drop_cnt !== '0 || bus.o_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL disable_ignore level=%0d drops=%0d want 0/0", bus.o_fifo_level, bus.o_drop_cnt);
        end
    endtask

    task automatic test_random();
        bit r, en, fv, rdy;
        tick(1, 0, 0, '0, 0);
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 499) == 0);
            en  = ($urandom_range(0, 39) != 0);
            fv  = ($urandom_range(0, 1) == 1);
            rdy = ((i / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick(r, en, fv, FW'($urandom), rdy);
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.i_enable     = 1'b0;
        bus.i_fine_valid = 1'b0;
        bus.i_fine_code  = '0;
        bus.i_tready     = 1'b0;
        test_reset();
        test_single_hit();
        test_rollover();
        test_wrap_hit();
        test_full_drop();
        test_full_marker();
        test_reset_mid();
        test_disable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tdc_stamp_fifo.md
Name: tdc_stamp_fifo

Overview:
- Downstream consumer of the fine-counting stage.
- Extends each fine code with a free-running coarse count, so every hit gets a full timestamp.
- Inserts a marker word each time the coarse counter rolls over.
- Buffers timestamps in a first-word-fall-through FIFO with a valid/ready output toward readout logic (ILA, DMA, UART packer).
- Runs in the sys_clk domain from the clock/reset generator.

Parameters:
- FINE_WIDTH, 16, width of the fine code from the fine-counting stage.
- COARSE_WIDTH, 16, width of the coarse cycle counter.
- FIFO_DEPTH, 16, number of FIFO entries; must be a power of two, ≥4.
- DROP_WIDTH, 16, width of the saturating drop counter.

Ports:
- i_clk  input  1  system clock (sys_clk).
- i_reset  input  1  synchronous active-high reset.
- i_enable  input  1  measurement enable; low clears the coarse counter and ignores hits.
- i_fine_valid  input  1  one-cycle strobe: i_fine_code holds a new hit.
- i_fine_code  input  FINE_WIDTH  fine code of the hit.
- o_tdata  output  1+COARSE_WIDTH+FINE_WIDTH  bits are {tag, coarse, fine}:
  - tag=0: hit word.
  - tag=1: rollover marker; coarse field = 0, fine field = rollover sequence number (low FINE_WIDTH bits).
- o_tvalid  output  1  FIFO head is valid.
- i_tready  input  1  consumer accepts the head word.
- o_fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_drop_cnt  output  DROP_WIDTH  hits lost to a full FIFO (saturating).
- o_marker_lost  output  1  sticky: a rollover marker could not be queued.

Behaviour:
- Reset: all of the following are cleared and o_tdata=0 on the cycle after i_reset is sampled high. Reset mid-transfer discards FIFO contents without handshake.
  - Coarse counter, FIFO pointers, o_tvalid=0, o_fifo_level=0, o_drop_cnt=0, o_marker_lost=0.
  - Marker-pending flag and rollover sequence counter.
- Coarse counter:
  - Increments every cycle while i_enable=1.
  - Wraps from 2^COARSE_WIDTH-1 to 0.
  - The wrap cycle sets marker-pending and increments the rollover sequence counter (modulo 2^FINE_WIDTH).
- Hit capture:
  - On i_fine_valid=1 and i_enable=1, register {0, coarse value in that same cycle, i_fine_code} into the input stage (cycle N).
  - The FIFO write occurs in cycle N+1.
  - The word is visible on o_tdata/o_tvalid in cycle N+2 if the FIFO was empty.
- Write arbitration (one FIFO write per cycle):
  - A registered hit has priority.
  - A pending marker is written in the first cycle with no registered hit; writing it clears marker-pending.
  - A new wrap while marker-pending is still set sets o_marker_lost; the pending marker remains with the updated sequence number.
- Full:
  - A write attempted when o_fifo_level==FIFO_DEPTH is discarded.
  - A hit discarded this way increments o_drop_cnt (saturating at all-ones).
  - A marker is not discarded while full; it stays pending.
  - Fullness is evaluated before a same-cycle pop, so a write is dropped even if a pop occurs in the same cycle.
- Read:
  - FIFO is first-word-fall-through.
  - A pop happens on o_tvalid & i_tready; the next word appears the following cycle.
  - o_tdata is stable while o_tvalid=1 and i_tready=0.
- Level: simultaneous write and pop leaves o_fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
- i_enable=0:
  - Coarse counter is held at 0; marker-pending and the sequence counter are cleared.
  - Hits are ignored and not counted as drops.
  - An already registered hit is still written.
  - The FIFO continues to drain.
- i_fine_valid on consecutive cycles: every hit is captured; throughput is one hit per cycle.

Test Plan:
- Reset, enable, i_tready=1, single hit with fine=0x00A5 at coarse=0x0010:
  - o_tvalid rises 2 cycles later with o_tdata={0,0x0010,0x00A5}.
  - o_fifo_level returns to 0 after the pop.
- Enable with no hits for 65536 cycles (COARSE_WIDTH=16): exactly one marker {1,0x0000,0x0001}. A second wrap yields fine field 0x0002.
- Hit in the wrap cycle (coarse=0xFFFF):
  - Hit word {0,0xFFFF,code} is output first.
  - The marker word follows in the next write cycle.
- i_tready=0, 20 hits on consecutive cycles, FIFO_DEPTH=16: o_fifo_level=16, o_drop_cnt=4, o_tdata holds the first hit. Then raise i_tready: 16 words drain in order.
- FIFO full with i_tready=0 across a coarse wrap:
  - Marker stays pending and o_marker_lost=0.
  - Pop one word → the marker is written.
  - A second wrap while still full sets o_marker_lost=1.
- Assert i_reset with 8 words queued and i_tready toggling: all outputs are 0 next cycle and no further words appear. Drive hits while i_enable=0: nothing is queued and o_drop_cnt is unchanged.
